alu_exec_unit: RTL

Parametrised execute-stage ALU for the pipelined core. It combines the ALU control decode (ALUOp/func3/func7) with the datapath. It extends the four-operation decode to the full RV32I integer set, adds I-type decode, and adds an iterative RV32M multiply/divide unit. Single-cycle operations return in one cycle; M-extension operations run multi-cycle behind a valid/ready handshake that stalls the pipeline.

---
 rtl/alu_exec_pkg.sv | 59 +++++
 rtl/alu_exec_if.sv | 26 ++
 rtl/mul_div_iter.sv | 117 +++++++++++
 rtl/alu_exec_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared decode constants, FSM state type and the base-op decode helper
// for the execute-stage ALU.
package alu_exec_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_XOR     = 4'b0011;
    localparam logic [3:0] OP_SLL     = 4'b0100;
    localparam logic [3:0] OP_SRL     = 4'b0101;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_SRA     = 4'b0111;
    localparam logic [3:0] OP_SLT     = 4'b1000;
    localparam logic [3:0] OP_SLTU    = 4'b1001;
    localparam logic [3:0] OP_INVALID = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // alt selects SUB/SRA over ADD/SRL
    function automatic logic [3:0] base_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            3'b111:  op = OP_AND;
            default: op = OP_INVALID;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operation/result bus between the issue stage and the execute ALU.
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, ALUOp, func3, func7, op_a, op_b,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, ALUOp, func3, func7, op_a, op_b,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/mul_div_iter.sv
// Iterative RV32M core: shift-add multiply / restoring divide on operand
// magnitudes, one bit per step, with sign fixup applied on the way out.
module mul_div_iter
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      mop,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            last,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);

    // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dv_q, dv_d;
    logic [2:0]        mop_q, mop_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   abs_a_s, abs_b_s;
    logic [XLEN:0]     sum_s, shl_s, diff_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    // Operand sign classification and magnitudes at start
    always_comb begin
        a_neg_s = 1'b0;
        b_neg_s = 1'b0;
        case (mop)
            M_MULH, M_DIV, M_REM: begin
                a_neg_s = op_a[XLEN-1];
                b_neg_s = op_b[XLEN-1];
            end
            M_MULHSU: a_neg_s = op_a[XLEN-1];
            default: begin
                a_neg_s = 1'b0;
                b_neg_s = 1'b0;
            end
        endcase
        abs_a_s = a_neg_s ? -op_a : op_a;
        abs_b_s = b_neg_s ? -op_b : op_b;
    end

    // Load on start, otherwise advance one multiply or divide bit per step
    always_comb begin
        sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dv_q} : {(XLEN+1){1'b0}});
        shl_s  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff_s = shl_s - {1'b0, dv_q};
        acc_d  = acc_q;
        dv_d   = dv_q;
        mop_d  = mop_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        if (start) begin
            acc_d = {{XLEN{1'b0}}, abs_a_s};
            dv_d  = abs_b_s;
            mop_d = mop;
            neg_d = (mop == M_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
            cnt_d = {CW{1'b0}};
        end else if (step) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (mop_q[2]) begin
                if (diff_s[XLEN]) begin
                    acc_d = {shl_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end
            end else begin
                acc_d = {sum_s, acc_q[XLEN-1:1]};
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Iteration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= {(2*XLEN){1'b0}};
            dv_q  <= {XLEN{1'b0}};
            mop_q <= 3'b000;
            neg_q <= 1'b0;
            cnt_q <= {CW{1'b0}};
        end else begin
            acc_q <= acc_d;
            dv_q  <= dv_d;
            mop_q <= mop_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CW'(XLEN-1));

    // Sign fixup and result selection
    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        quo_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (mop_q)
            M_MUL:                     res = prod_s[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: res = prod_s[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             res = quo_s;
            M_REM, M_REMU:             res = rem_s;
            default:                   res = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALUOp/func3/func7 decode, single-cycle RV32I datapath,
// and the handshake/flush control around the iterative M-extension core.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    alu_exec_if.slave bus
);
    localparam int              SHW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      op_s;
    logic            mop_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic            div_zero_s, div_ovf_s, special_s;
    logic [XLEN-1:0] special_res_s, sc_res_s;
    logic            accept_s, md_start_s, md_step_s, md_last_s;
    logic [XLEN-1:0] md_res_s;

    // Instruction decode to op code or M-op flag
    always_comb begin
        op_s  = OP_INVALID;
        mop_s = 1'b0;
        case (bus.ALUOp)
            ALUOP_ADD: op_s = OP_ADD;
            ALUOP_SUB: op_s = OP_SUB;
            ALUOP_RTYPE: begin
                if (bus.func7 == F7_BASE) begin
                    op_s = base_op(bus.func3, 1'b0);
                end else if ((bus.func7 == F7_ALT) && ((bus.func3 == 3'b000) || (bus.func3 == 3'b101))) begin
                    op_s = base_op(bus.func3, 1'b1);
                end else if ((bus.func7 == F7_MEXT) && ENABLE_M) begin
                    mop_s = 1'b1;
                end else begin
                    op_s = OP_INVALID;
                end
            end
            ALUOP_ITYPE: begin
                // func7 is immediate bits except for the shift-right-immediate pair
                if (bus.func3 == 3'b101) begin
                    if (bus.func7 == F7_BASE) begin
                        op_s = OP_SRL;
                    end else if (bus.func7 == F7_ALT) begin
                        op_s = OP_SRA;
                    end else begin
                        op_s = OP_INVALID;
                    end
                end else begin
                    op_s = base_op(bus.func3, 1'b0);
                end
            end
            default: op_s = OP_INVALID;
        endcase
    end

    assign shamt_s = bus.op_b[SHW-1:0];

    // Single-cycle datapath
    always_comb begin
        alu_res_s = ZERO;
        case (op_s)
            OP_AND:  alu_res_s = bus.op_a & bus.op_b;
            OP_OR:   alu_res_s = bus.op_a | bus.op_b;
            OP_ADD:  alu_res_s = bus.op_a + bus.op_b;
            OP_XOR:  alu_res_s = bus.op_a ^ bus.op_b;
            OP_SLL:  alu_res_s = bus.op_a << shamt_s;
            OP_SRL:  alu_res_s = bus.op_a >> shamt_s;
            OP_SUB:  alu_res_s = bus.op_a - bus.op_b;
            OP_SRA:  alu_res_s = $signed(bus.op_a) >>> shamt_s;
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
            default: alu_res_s = ZERO;
        endcase
    end

    // Divide-by-zero and signed overflow bypass the iterative core
    always_comb begin
        div_zero_s = (bus.op_b == ZERO);
        div_ovf_s  = ~bus.func3[0] & (bus.op_a == MOST_NEG) & (bus.op_b == ONES);
        special_s  = mop_s & bus.func3[2] & (div_zero_s | div_ovf_s);
        if (div_zero_s) begin
            special_res_s = bus.func3[1] ? bus.op_a : ONES;
        end else begin
            special_res_s = bus.func3[1] ? ZERO : bus.op_a;
        end
        sc_res_s = mop_s ? special_res_s : alu_res_s;
    end

    assign accept_s = bus.in_valid & bus.in_ready;

    mul_div_iter #(.XLEN(XLEN)) u_md (
        .clk   (clk),
        .reset (reset),
        .start (md_start_s),
        .step  (md_step_s),
        .mop   (bus.func3),
        .op_a  (bus.op_a),
        .op_b  (bus.op_b),
        .last  (md_last_s),
        .res   (md_res_s)
    );

    // Handshake FSM and result capture
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        md_start_s  = 1'b0;
        md_step_s   = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && mop_s && !special_s) begin
                        md_start_s = 1'b1;
                        state_d    = bus.func3[2] ? ST_DIV : ST_MUL;
                    end else if (accept_s) begin
                        out_valid_d = 1'b1;
                        result_d    = sc_res_s;
                        zero_d      = (sc_res_s == ZERO);
                        illegal_d   = ~mop_s & (op_s == OP_INVALID);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    md_step_s = 1'b1;
                    if (md_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DONE: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = md_res_s;
                    zero_d      = (md_res_s == ZERO);
                    illegal_d   = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= ZERO;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule
